a_chan_arbiter: RTL and testbench
=================================

// Module: a_chan_arbiter
// PURPOSE
// - Shares the single A channel (a_valid/a_opcode/a_beat/a_data) among NUM_REQ requesters.
// - Uses round-robin arbitration with burst locking: a grant is held until the last beat of the burst completes.
// - Sits between the testbench-driver requesters and the DUT A-channel sink.
// - Sequences the beat index onto a_beat and flags the final beat on a_last.
// PARAMETERS
// - NUM_REQ  4  number of requesters, legal range 2..8
// - IDX_W    $clog2(NUM_REQ)  grant index width, derived, not overridden
// PORTS
// - clk           in   1           clock, all state on posedge
// - reset         in   1           synchronous, active-high
// - req_valid     in   NUM_REQ     per-requester beat valid
// - req_ready     out  NUM_REQ     per-requester beat accepted
// - req_opcode    in   NUM_REQ*4   per-requester opcode, sampled at grant
// - req_len       in   NUM_REQ*2   per-requester beats-1 (0..3), sampled at grant
// - req_data      in   NUM_REQ*8   per-requester beat data, forwarded live
// - a_valid       out  1           downstream beat valid
// - a_ready       in   1           downstream accepts beat
// - a_opcode      out  4           opcode of the current burst
// - a_beat        out  2           beat index within the burst, 0..len
// - a_data        out  8           beat data
// - a_last        out  1           current beat is the final beat
// - grant_idx     out  IDX_W       current owner; valid only in BURST
// - grant_count   out  NUM_REQ*16  present only with A_ARB_PERF_EN; see CONFIGURATION
// BEHAVIOUR
// - Reset values:
//   - FSM=IDLE, rr_ptr=0, beat=0, grant_idx=0.
//   - All outputs 0, including req_ready and a_valid.
// - FSM state IDLE:
//   - a_valid=0, req_ready=0.
//   - If any req_valid is high, pick the first set bit searching upward from rr_ptr, with wrap.
//   - Latch grant_idx, opcode=req_opcode[g] and len=req_len[g]; clear beat; go to BURST next cycle.
//   - This gives 1 arbitration bubble cycle per burst.
// - FSM state BURST:
//   - Combinational forwarding:
//     - a_valid = req_valid[g]; a_data = req_data[g]; req_ready[g] = a_ready.
//     - Every other req_ready = 0.
//   - Registered outputs: a_opcode = latched opcode; a_beat = beat; a_last = (beat == len).
//   - A handshake is a_valid & a_ready:
//     - Not last beat: beat increments.
//     - Last beat: go to IDLE, rr_ptr = (g + 1) mod NUM_REQ, beat = 0.
// - The owner dropping req_valid mid-burst only stalls the burst: a_valid=0 and the grant is held. There is no timeout.
// - Changes to req_opcode/req_len after the grant are ignored until the next grant.
// - Requests from non-owners during BURST are ignored; they compete at the next IDLE.
// - A single beat (len=0) completes IDLE->BURST->IDLE in 2 cycles with a_ready=1.
// - rr_ptr wraps from NUM_REQ-1 to 0. A lone requester is re-granted every 2 cycles.
// - Reset asserted mid-burst:
//   - Abandon the burst and apply all reset values on the next edge.
//   - No beat is accepted in that cycle, because req_ready is forced to 0 while reset=1.
// - Width rule: beat is 2 bits and never exceeds len, so it never wraps.
// CONFIGURATION
// - Macro A_ARB_PERF_EN defined:
//   - Adds port grant_count with one 16-bit counter per requester.
//   - A counter increments by 1 on each completed burst (last-beat handshake) of its requester.
//   - Counters saturate at 16'hFFFF and clear on reset.
// - Macro not defined: the port, counters and logic are absent; nothing else changes.
// STRUCTURE
// - Package a_chan_pkg:
//   - typedef a_opcode_t (logic [3:0]); typedef a_beat_t (logic [1:0]); typedef a_data_t (logic [7:0]).
//   - typedef enum {ARB_IDLE, ARB_BURST} arb_state_t.
//   - Constant CNT_W = 16.
// - Sub-module rr_pick:
//   - Purely combinational.
//   - Inputs: req vector and rr_ptr. Outputs: any_req and winner index.
// - The FSM, latches, muxes and perf counters stay in a_chan_arbiter.
// TESTING
// - Contention:
//   - Stimulus: reset for 2 cycles, then req_valid=4'b1111, all len=0, a_ready=1.
//   - Required: grants go 0,1,2,3,0; each burst has a_last=1 and a_beat=0.
// - Burst lock:
//   - Stimulus: req0 len=3 data 8'h10..8'h13; req1 valid throughout.
//   - Required: a_beat=0,1,2,3 carrying 8'h10..8'h13; a_last only on beat 3; req1 granted next.
// - Backpressure:
//   - Stimulus: a_ready low for 3 cycles during beat 1.
//   - Required: a_beat, a_data and a_opcode hold steady; req_ready[g]=0; no beat is lost.
// - Owner stall:
//   - Stimulus: req2 drops req_valid for 2 cycles mid-burst.
//   - Required: a_valid=0 and grant_idx stays 2; the burst resumes at the same beat.
// - Reset mid-burst:
//   - Stimulus: assert reset on beat 2 of a len=3 burst.
//   - Required: next cycle FSM=IDLE, all outputs 0; after release, the grant search starts at index 0.
// - With A_ARB_PERF_EN:
//   - Stimulus: 5 bursts from req3.
//   - Required: grant_count[3]=5 and all other counters 0.

Source files
------------

// File: rtl/a_chan_pkg.sv
// Shared types and constants for the A-channel arbiter slice.
package a_chan_pkg;

    typedef logic [3:0] a_opcode_t;
    typedef logic [1:0] a_beat_t;
    typedef logic [7:0] a_data_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/a_chan_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any_req,
    output logic [IDX_W-1:0]   winner
);

    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        winner  = '0;
        any_req = |req;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/a_chan_arbiter.sv
// A-channel arbiter: round-robin grant held for a whole burst, beat sequencing.
// Optional per-requester completed-burst counters when A_ARB_PERF_EN is defined.
//
// state      | meaning
// ARB_IDLE   | no owner; pick a winner and latch its opcode/len (one bubble cycle)
// ARB_BURST  | owner's beats forwarded until the last-beat handshake
module a_chan_arbiter
    import a_chan_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*4-1:0] req_opcode,
    input  logic [NUM_REQ*2-1:0] req_len,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [3:0]           a_opcode,
    output logic [1:0]           a_beat,
    output logic [7:0]           a_data,
    output logic                 a_last,
    output logic [IDX_W-1:0]     grant_idx
`ifdef A_ARB_PERF_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_count
`endif
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    a_opcode_t        opcode_q, opcode_d;
    a_beat_t          len_q, len_d;
    a_beat_t          beat_q, beat_d;
    logic             any_req;
    logic [IDX_W-1:0] winner;
    logic             hs;

    a_opcode_t op_arr   [NUM_REQ];
    a_beat_t   len_arr  [NUM_REQ];
    a_data_t   data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i]   = req_opcode[i*4 +: 4];
        assign len_arr[i]  = req_len[i*2 +: 2];
        assign data_arr[i] = req_data[i*8 +: 8];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            opcode_q <= '0;
            len_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            opcode_q <= opcode_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
        end
    end

    // Handshake signals are gated by reset so no beat is taken while the burst is abandoned.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        opcode_d  = opcode_q;
        len_d     = len_q;
        beat_d    = beat_q;
        a_valid   = 1'b0;
        a_data    = '0;
        req_ready = '0;
        a_opcode  = '0;
        a_beat    = '0;
        a_last    = 1'b0;
        hs        = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d  = winner;
                    opcode_d = op_arr[winner];
                    len_d    = len_arr[winner];
                    beat_d   = '0;
                    state_d  = ARB_BURST;
                end
            end
            ARB_BURST: begin
                a_valid            = req_valid[grant_q] & ~reset;
                a_data             = data_arr[grant_q];
                req_ready[grant_q] = a_ready & ~reset;
                a_opcode           = opcode_q;
                a_beat             = beat_q;
                a_last             = (beat_q == len_q);
                hs                 = a_valid & a_ready;
                if (hs) begin
                    if (a_last) begin
                        state_d = ARB_IDLE;
                        beat_d  = '0;
                        if (grant_q == IDX_W'(NUM_REQ - 1)) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = grant_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign grant_idx = grant_q;

`ifdef A_ARB_PERF_EN
    logic             burst_done;
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    assign burst_done = hs & a_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (burst_done && (cnt_q[grant_q] != {CNT_W{1'b1}})) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt_pack
        assign grant_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_a_chan_arbiter.sv
// Self-checking bench for a_chan_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_a_chan_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*4-1:0] req_opcode;
    logic [N*2-1:0] req_len;
    logic [N*8-1:0] req_data;
    logic           a_valid;
    logic           a_ready;
    logic [3:0]     a_opcode;
    logic [1:0]     a_beat;
    logic [7:0]     a_data;
    logic           a_last;
    logic [1:0]     grant_idx;
`ifdef A_ARB_PERF_EN
    logic [N*16-1:0] grant_count;
`endif

    always #5 clk = ~clk;

    a_chan_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_len    (req_len),
        .req_data   (req_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_opcode   (a_opcode),
        .a_beat     (a_beat),
        .a_data     (a_data),
        .a_last     (a_last),
        .grant_idx  (grant_idx)
`ifdef A_ARB_PERF_EN
        ,
        .grant_count(grant_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner, latched burst parameters, beat position, pointer.
    bit m_on = 0;
    bit m_busy;
    int m_owner, m_op, m_len, m_beat, m_ptr;
    int m_cnt [N];

    always @(posedge clk) begin
        bit found;
        int idx;
        found = 0;
        idx   = 0;
        if (reset) begin
            m_on = 1; m_busy = 0; m_owner = 0; m_op = 0; m_len = 0; m_beat = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_on) begin
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && req_valid[idx]) begin
                        found   = 1;
                        m_busy  = 1;
                        m_owner = idx;
                        m_op    = int'(req_opcode[idx*4 +: 4]);
                        m_len   = int'(req_len[idx*2 +: 2]);
                        m_beat  = 0;
                    end
                end
            end else if (req_valid[m_owner] && a_ready) begin
                if (m_beat == m_len) begin
                    m_busy = 0;
                    m_beat = 0;
                    m_ptr  = (m_owner + 1) % N;
                    if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    typedef struct {
        int g;
        int beat;
        int data;
        bit last;
    } hs_t;
    hs_t log_q[$];

    logic [N-1:0] exp_rdy;
    logic [63:0]  exp_cnt;

    always @(negedge clk) begin
        if (m_on) begin
            exp_rdy = '0;
            if (m_busy && !reset && a_ready) exp_rdy[m_owner] = 1'b1;
            check("a_valid", a_valid, (m_busy && req_valid[m_owner] && !reset) ? 1 : 0);
            check("a_data", a_data, m_busy ? req_data[m_owner*8 +: 8] : 8'h0);
            check("req_ready", req_ready, exp_rdy);
            check("a_opcode", a_opcode, m_busy ? m_op : 0);
            check("a_beat", a_beat, m_busy ? m_beat : 0);
            check("a_last", a_last, (m_busy && m_beat == m_len) ? 1 : 0);
            if (m_busy) check("grant_idx", grant_idx, m_owner);
`ifdef A_ARB_PERF_EN
            exp_cnt = '0;
            for (int i = 0; i < N; i++) exp_cnt[i*16 +: 16] = m_cnt[i][15:0];
            check("grant_count", grant_count, exp_cnt);
`endif
            if (a_valid && a_ready && !reset)
                log_q.push_back('{int'(grant_idx), int'(a_beat), int'(a_data), a_last});
        end
    end

    // Owner data tracks its beat index so forwarded data identifies the beat.
    bit auto_data = 1;
    always @(posedge clk) begin
        #1;
        if (auto_data)
            for (int i = 0; i < N; i++)
                req_data[i*8 +: 8] = 8'((i + 1) * 16 + ((m_busy && m_owner == i) ? m_beat : 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (log_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check("handshake_count_timeout", log_q.size() >= n, 1);
    endtask

    task automatic wait_beat(input int b, input int budget);
        int c = 0;
        while (!(m_busy && m_beat == b) && c < budget) begin
            tick();
            c++;
        end
        check("wait_beat_timeout", (m_busy && m_beat == b) ? 1 : 0, 1);
    endtask

    initial begin
        int exp_g [5] = '{0, 1, 2, 3, 0};
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g [5] = '{0, 1, 2, 3, 0};
        reset = 1; req_valid = '0; req_opcode = '0; req_len = '0; req_data = '0; a_ready = 0;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        check("rst_a_valid", a_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_idx", grant_idx, 0);
        tick();

        // Contention, single-beat bursts
        req_opcode = 16'h4321; req_len = '0; a_ready = 1; req_valid = 4'b1111;
        log_q.delete();
        wait_log(5, 40);
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            check("cont_grant", log_q[k].g, exp_g[k]);
            check("cont_beat", log_q[k].beat, 0);
            check("cont_last", log_q[k].last, 1);
        end

        // Burst lock from index 0
        reset = 1; tick(); reset = 0;
        req_len = 8'b00_00_00_11; req_valid = 4'b0011; a_ready = 1;
        log_q.delete();
        wait_log(5, 40);
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            check("lock_grant", log_q[k].g, 0);
            check("lock_beat", log_q[k].beat, k);
            check("lock_data", log_q[k].data, 8'h10 + k);
            check("lock_last", log_q[k].last, (k == 3) ? 1 : 0);
        end
        check("lock_next_grant", log_q[4].g, 1);

        // Backpressure then owner stall on requester 2
        req_len = 8'b00_11_00_00; req_opcode = 16'h0A00; req_valid = 4'b0100; a_ready = 1;
        log_q.delete();
        wait_beat(1, 20);
        a_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_beat", a_beat, 1);
            check("bp_data", a_data, 8'h31);
            check("bp_opcode", a_opcode, 4'hA);
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        a_ready = 1;
        wait_beat(2, 20);
        req_valid = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_a_valid", a_valid, 0);
            check("stall_grant", grant_idx, 2);
            check("stall_beat", a_beat, 2);
            tick();
        end
        req_valid = 4'b0100;
        wait_log(4, 40);
        req_valid = '0;
        tick(); tick();
        check("bp_hs_total", log_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("bp_log_grant", log_q[k].g, 2);
            check("bp_log_beat", log_q[k].beat, k);
            check("bp_log_data", log_q[k].data, 8'h30 + k);
        end

        // Reset mid-burst on requester 3
        req_len = 8'b11_00_00_00; req_opcode = 16'h7000; req_valid = 4'b1000; a_ready = 1;
        wait_beat(2, 20);
        reset = 1;
        log_q.delete();
        @(negedge clk);
        check("rstmid_req_ready", req_ready, 0);
        tick();
        reset = 0; req_len = '0; req_valid = 4'b1010;
        @(negedge clk);
        check("rstmid_a_valid", a_valid, 0);
        check("rstmid_a_beat", a_beat, 0);
        check("rstmid_a_opcode", a_opcode, 0);
        check("rstmid_a_last", a_last, 0);
        check("rstmid_grant_idx", grant_idx, 0);
        tick();
        wait_log(1, 10);
        req_valid = '0;
        check("rstmid_first_grant", log_q[0].g, 1);
        tick(); tick();

`ifdef A_ARB_PERF_EN
        reset = 1; tick(); reset = 0;
        req_len = '0; req_valid = 4'b1000; a_ready = 1;
        log_q.delete();
        wait_log(5, 40);
        req_valid = '0;
        tick(); tick();
        check("perf_cnt3", grant_count[63:48], 5);
        check("perf_cnt_others", grant_count[47:0], 0);
`endif

        // Random traffic
        auto_data = 0;
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            req_valid  = N'($urandom);
            a_ready    = ($urandom_range(0, 3) != 0);
            req_opcode = 16'($urandom);
            req_len    = 8'($urandom);
            req_data   = 32'($urandom);
            tick();
        end
        reset = 0; req_valid = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
